// File: rtl/rotshift_pipe.sv
// Pipelined barrel rotator/shifter (ROR/ROL/SHR/SAR), one amount bit per stage, LSB stage first.
// Latency AMT_W stages, bubble-collapsing valid/ready backpressure; ROTSHIFT_STATS_EN adds transfer/stall counters.
module rotshift_pipe #(
    parameter int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef ROTSHIFT_STATS_EN
    ,
    output logic [31:0]      stat_xfers,
    output logic [31:0]      stat_stalls,
    input  logic             stat_clr
`endif
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_SHR = 2'b10;
    localparam logic [1:0] MODE_SAR = 2'b11;

    generate
        if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $fatal(1, "rotshift_pipe: WIDTH must be a power of two and at least 4");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] m,
                                                 input int sh);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SHR: r = d >> sh;
            MODE_SAR: r = $signed(d) >>> sh;
            default:  r = (d >> sh) | (d << (WIDTH - sh));
        endcase
        return r;
    endfunction

    logic [AMT_W-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] dat_q  [AMT_W];
    logic [WIDTH-1:0] dat_d  [AMT_W];
    logic [AMT_W-1:0] amt_q  [AMT_W];
    logic [AMT_W-1:0] amt_d  [AMT_W];
    logic [1:0]       mode_q [AMT_W];
    logic [1:0]       mode_d [AMT_W];

    logic [AMT_W-1:0] adv;
    logic             in_fire;
    logic [AMT_W-1:0] amt_eff;
    logic [1:0]       mode_eff;
    logic             unused_bits;

    always_comb begin
        adv = '0;
        adv[AMT_W-1] = vld_q[AMT_W-1] && out_ready;
        for (int k = AMT_W - 2; k >= 0; k--) begin
            adv[k] = vld_q[k] && (!vld_q[k+1] || adv[k+1]);
        end
        in_ready = !vld_q[0] || adv[0];
        in_fire  = in_valid && in_ready;

        // ROL by n is ROR by (WIDTH - n) mod WIDTH; the amount register wraps naturally
        amt_eff  = (in_mode == MODE_ROL) ? ('0 - in_amt) : in_amt;
        mode_eff = (in_mode == MODE_ROL) ? MODE_ROR : in_mode;

        vld_d  = vld_q;
        dat_d  = dat_q;
        amt_d  = amt_q;
        mode_d = mode_q;

        if (in_fire) begin
            vld_d[0]  = 1'b1;
            dat_d[0]  = amt_eff[0] ? stage_op(in_data, mode_eff, 1) : in_data;
            amt_d[0]  = amt_eff;
            mode_d[0] = mode_eff;
        end else if (adv[0]) begin
            vld_d[0] = 1'b0;
        end

        for (int k = 1; k < AMT_W; k++) begin
            if (adv[k-1]) begin
                vld_d[k]  = 1'b1;
                dat_d[k]  = amt_q[k-1][k] ? stage_op(dat_q[k-1], mode_q[k-1], 1 << k)
                                          : dat_q[k-1];
                amt_d[k]  = amt_q[k-1];
                mode_d[k] = mode_q[k-1];
            end else if (adv[k]) begin
                vld_d[k] = 1'b0;
            end
        end

        unused_bits = ^mode_q[AMT_W-1];
        for (int k = 0; k < AMT_W; k++) begin
            unused_bits = unused_bits ^ (^amt_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < AMT_W; k++) begin
                dat_q[k]  <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            amt_q  <= amt_d;
            mode_q <= mode_d;
        end
    end

    assign out_valid = vld_q[AMT_W-1];
    assign out_data  = dat_q[AMT_W-1];

`ifdef ROTSHIFT_STATS_EN
    logic [31:0] xfers_q, xfers_d;
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        xfers_d  = xfers_q;
        stalls_d = stalls_q;
        if (stat_clr) begin
            xfers_d  = '0;
            stalls_d = '0;
        end else begin
            if (out_valid && out_ready && xfers_q != 32'hFFFF_FFFF) begin
                xfers_d = xfers_q + 32'd1;
            end
            if (out_valid && !out_ready && stalls_q != 32'hFFFF_FFFF) begin
                stalls_d = stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfers_q  <= '0;
            stalls_q <= '0;
        end else begin
            xfers_q  <= xfers_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_xfers  = xfers_q;
    assign stat_stalls = stalls_q;
`endif

endmodule
